// File: rtl/data_mem_io_if.sv
// Datapath-side load/store bus plus the byte-wide transmit stream of the data memory/IO unit.
interface data_mem_io_if;
   logic        MemWrite;
   logic [31:0] Addr;
   logic [31:0] WriteData;
   logic [31:0] ReadData;
   logic [7:0]  TxData;
   logic        TxValid;
   logic        TxReady;

   modport master (
      output MemWrite, Addr, WriteData, TxReady,
      input  ReadData, TxData, TxValid
   );

   modport slave (
      input  MemWrite, Addr, WriteData, TxReady,
      output ReadData, TxData, TxValid
   );
endinterface

// File: rtl/data_mem_io.sv
// Word-addressed data RAM plus memory-mapped TX FIFO, status register and free-running cycle counter.
// Loads are combinational; every state change happens on the rising edge of clk.
module data_mem_io #(
   parameter int RAM_WORDS  = 64,
   parameter int FIFO_DEPTH = 8
) (
   input  logic         clk,
   input  logic         rst,
   data_mem_io_if.slave bus
);
   localparam int AW = $clog2(RAM_WORDS);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   localparam logic [31:0] ADDR_TXDATA = 32'h0000_1000;
   localparam logic [31:0] ADDR_STATUS = 32'h0000_1004;
   localparam logic [31:0] ADDR_CYCLES = 32'h0000_1008;

   logic [31:0] word_addr;
   logic        unused_addr_bits;
   logic        sel_ram, sel_tx, sel_status, sel_cycles;
   logic [AW-1:0] ram_idx;

   assign word_addr        = {bus.Addr[31:2], 2'b00};
   assign unused_addr_bits = ^bus.Addr[1:0];
   assign sel_ram          = (word_addr < 32'(4 * RAM_WORDS));
   assign sel_tx           = (word_addr == ADDR_TXDATA);
   assign sel_status       = (word_addr == ADDR_STATUS);
   assign sel_cycles       = (word_addr == ADDR_CYCLES);
   assign ram_idx          = bus.Addr[AW+1:2];

   logic [31:0] ram_q [RAM_WORDS];

   // RAM survives reset, but a store issued during a reset cycle is still discarded.
   always_ff @(posedge clk) begin
      if (!rst && bus.MemWrite && sel_ram) begin
         ram_q[ram_idx] <= bus.WriteData;
      end
   end

   logic [7:0]    buf_q [FIFO_DEPTH];
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          overflow_q, overflow_d;
   logic [7:0]    last_q, last_d;
   logic [31:0]   cycles_q, cycles_d;

   logic push, pop, push_ok, fifo_full, fifo_empty;

   assign fifo_empty = (count_q == '0);
   assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
   assign push       = bus.MemWrite && sel_tx;
   assign pop        = !fifo_empty && bus.TxReady;
   assign push_ok    = push && (!fifo_full || pop);

   always_comb begin
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      last_d     = last_q;
      cycles_d   = cycles_q + 32'd1;

      if (pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
         last_d   = buf_q[rd_ptr_q];
      end
      if (push_ok) begin
         wr_ptr_d = wr_ptr_q + PW'(1);
      end
      case ({push_ok, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase

      if (push && !push_ok) begin
         overflow_d = 1'b1;
      end else if (bus.MemWrite && sel_status && bus.WriteData[2]) begin
         overflow_d = 1'b0;
      end

      if (bus.MemWrite && sel_cycles) begin
         cycles_d = bus.WriteData;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         last_q     <= '0;
         cycles_q   <= '0;
      end else begin
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         last_q     <= last_d;
         cycles_q   <= cycles_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && push_ok) begin
         buf_q[wr_ptr_q] <= bus.WriteData[7:0];
      end
   end

   // While empty, the head slot may hold stale bytes, so the last popped (or reset) byte is shown instead.
   assign bus.TxValid = !fifo_empty;
   assign bus.TxData  = fifo_empty ? last_q : buf_q[rd_ptr_q];

   logic [31:0] status;
   assign status = {24'b0, 4'(count_q), 1'b0, overflow_q, fifo_empty, fifo_full};

   always_comb begin
      bus.ReadData = '0;
      if (sel_ram) begin
         bus.ReadData = ram_q[ram_idx];
      end else if (sel_status) begin
         bus.ReadData = status;
      end else if (sel_cycles) begin
         bus.ReadData = cycles_q;
      end
   end
endmodule

// File: tb/tb_data_mem_io.sv
// Self-checking bench for data_mem_io: directed vector table, multi-cycle corner sequences,
// then randomized traffic against a queue-based reference model.
module tb_data_mem_io;
   localparam int DEPTH = 8;
   localparam int WORDS = 64;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   data_mem_io_if bus ();

   data_mem_io #(.RAM_WORDS(WORDS), .FIFO_DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int n_pass  = 0;
   int n_total = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
   endtask

   // reference model
   logic [7:0]  m_q [$];
   bit          m_ov = 1'b0;
   logic [31:0] m_cyc = '0;
   logic [7:0]  m_last = '0;
   logic [31:0] m_ram [WORDS];
   bit          m_ram_ok [WORDS];

   initial for (int i = 0; i < WORDS; i++) m_ram_ok[i] = 1'b0;

   task automatic model_step();
      logic [31:0] a;
      a = bus.Addr & 32'hFFFF_FFFC;
      if (rst) begin
         m_q.delete();
         m_ov   = 1'b0;
         m_cyc  = '0;
         m_last = '0;
      end else begin
         if (m_q.size() > 0 && bus.TxReady) m_last = m_q.pop_front();
         if (bus.MemWrite) begin
            if (a < 32'(4 * WORDS)) begin
               m_ram[a >> 2]    = bus.WriteData;
               m_ram_ok[a >> 2] = 1'b1;
            end
            if (a == 32'h1000) begin
               if (m_q.size() < DEPTH) m_q.push_back(bus.WriteData[7:0]);
               else m_ov = 1'b1;
            end
            if (a == 32'h1004 && bus.WriteData[2]) m_ov = 1'b0;
         end
         if (bus.MemWrite && a == 32'h1008) m_cyc = bus.WriteData;
         else m_cyc = m_cyc + 32'd1;
      end
   endtask

   task automatic model_read(input logic [31:0] addr, output bit known, output logic [31:0] val);
      logic [31:0] a;
      int n;
      a = addr & 32'hFFFF_FFFC;
      n = m_q.size();
      known = 1'b1;
      val = '0;
      if (a < 32'(4 * WORDS)) begin
         known = m_ram_ok[a >> 2];
         val   = m_ram[a >> 2];
      end else if (a == 32'h1004) begin
         val = {24'b0, 4'(n), 1'b0, m_ov, (n == 0), (n == DEPTH)};
      end else if (a == 32'h1008) begin
         val = m_cyc;
      end
   endtask

   task automatic drive(input bit r, input bit mw, input logic [31:0] a, input logic [31:0] d,
                        input bit rdy);
      rst           = r;
      bus.MemWrite  = mw;
      bus.Addr      = a;
      bus.WriteData = d;
      bus.TxReady   = rdy;
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      bit          rst;
      bit          mw;
      logic [31:0] addr;
      logic [31:0] wd;
      bit          rdy;
      bit          chk_rd;
      logic [31:0] exp_rd;
      bit          exp_valid;
      logic [7:0]  exp_tx;
   } vec_t;

   vec_t tbl [13];

   initial begin
      bit known;
      logic [31:0] exp_rd;
      logic [31:0] a, d;
      bit mw, rdy, r;
      int sel;

      tbl[0]  = '{1'b0, 1'b1, 32'h0000_0008, 32'h1122_3344, 1'b0, 1'b0, 32'h0, 1'b0, 8'h00};
      tbl[1]  = '{1'b0, 1'b1, 32'h0000_0004, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0, 1'b0, 8'h00};
      tbl[2]  = '{1'b0, 1'b0, 32'h0000_0004, 32'h0,         1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 8'h00};
      tbl[3]  = '{1'b0, 1'b0, 32'h0000_0008, 32'h0,         1'b0, 1'b1, 32'h1122_3344, 1'b0, 8'h00};
      tbl[4]  = '{1'b0, 1'b0, 32'h0000_2000, 32'h0,         1'b0, 1'b1, 32'h0,  1'b0, 8'h00};
      tbl[5]  = '{1'b0, 1'b0, 32'h0000_1004, 32'h0,         1'b0, 1'b1, 32'h02, 1'b0, 8'h00};
      tbl[6]  = '{1'b0, 1'b1, 32'h0000_1000, 32'h48,        1'b0, 1'b1, 32'h0,  1'b0, 8'h00};
      tbl[7]  = '{1'b0, 1'b1, 32'h0000_1000, 32'h49,        1'b0, 1'b1, 32'h0,  1'b1, 8'h48};
      tbl[8]  = '{1'b0, 1'b0, 32'h0000_1004, 32'h0,         1'b0, 1'b1, 32'h20, 1'b1, 8'h48};
      tbl[9]  = '{1'b0, 1'b0, 32'h0000_1004, 32'h0,         1'b1, 1'b1, 32'h20, 1'b1, 8'h48};
      tbl[10] = '{1'b0, 1'b0, 32'h0000_1004, 32'h0,         1'b1, 1'b1, 32'h10, 1'b1, 8'h49};
      tbl[11] = '{1'b0, 1'b0, 32'h0000_1004, 32'h0,         1'b1, 1'b1, 32'h02, 1'b0, 8'h49};
      tbl[12] = '{1'b0, 1'b0, 32'h0000_1000, 32'h0,         1'b0, 1'b1, 32'h0,  1'b0, 8'h49};

      drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
      tick();
      tick();

      for (int i = 0; i < 13; i++) begin
         drive(tbl[i].rst, tbl[i].mw, tbl[i].addr, tbl[i].wd, tbl[i].rdy);
         #1;
         if (tbl[i].chk_rd) chk($sformatf("vec%0d ReadData", i), bus.ReadData, tbl[i].exp_rd);
         chk($sformatf("vec%0d TxValid", i), 32'(bus.TxValid), 32'(tbl[i].exp_valid));
         chk($sformatf("vec%0d TxData", i), 32'(bus.TxData), 32'(tbl[i].exp_tx));
         tick();
      end

      // overflow: ninth push dropped, sticky flag cleared by STATUS store, order preserved
      drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
      tick();
      for (int i = 0; i < 9; i++) begin
         drive(1'b0, 1'b1, 32'h1000, 32'(8'hA0 + i), 1'b0);
         tick();
      end
      drive(1'b0, 1'b0, 32'h1004, 32'h0, 1'b0);
      #1;
      chk("ovf status", bus.ReadData, 32'h85);
      drive(1'b0, 1'b1, 32'h1004, 32'h4, 1'b0);
      tick();
      drive(1'b0, 1'b0, 32'h1004, 32'h0, 1'b0);
      #1;
      chk("ovf cleared", bus.ReadData, 32'h81);
      for (int i = 0; i < 8; i++) begin
         drive(1'b0, 1'b0, 32'h1004, 32'h0, 1'b1);
         #1;
         chk($sformatf("ovf drain%0d valid", i), 32'(bus.TxValid), 32'h1);
         chk($sformatf("ovf drain%0d data", i), 32'(bus.TxData), 32'(8'hA0 + i));
         tick();
      end
      drive(1'b0, 1'b0, 32'h1004, 32'h0, 1'b0);
      #1;
      chk("ovf end status", bus.ReadData, 32'h02);

      // full FIFO: push and pop on the same edge
      drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
      tick();
      for (int i = 0; i < 8; i++) begin
         drive(1'b0, 1'b1, 32'h1000, 32'(8'hB0 + i), 1'b0);
         tick();
      end
      drive(1'b0, 1'b1, 32'h1000, 32'hB8, 1'b1);
      #1;
      chk("full head", 32'(bus.TxData), 32'hB0);
      tick();
      drive(1'b0, 1'b0, 32'h1004, 32'h0, 1'b0);
      #1;
      chk("full pushpop status", bus.ReadData, 32'h81);
      for (int i = 0; i < 8; i++) begin
         drive(1'b0, 1'b0, 32'h1004, 32'h0, 1'b1);
         #1;
         chk($sformatf("full drain%0d", i), 32'(bus.TxData), 32'(8'hB1 + i));
         tick();
      end
      drive(1'b0, 1'b0, 32'h1004, 32'h0, 1'b0);
      #1;
      chk("full drained valid", 32'(bus.TxValid), 32'h0);

      // cycle counter count, load and wrap
      drive(1'b1, 1'b0, 32'h1008, 32'h0, 1'b0);
      tick();
      for (int i = 0; i < 10; i++) begin
         drive(1'b0, 1'b0, 32'h1008, 32'h0, 1'b0);
         tick();
      end
      chk("cycles at 10", bus.ReadData, 32'd10);
      drive(1'b0, 1'b1, 32'h1008, 32'hFFFF_FFFE, 1'b0);
      tick();
      drive(1'b0, 1'b0, 32'h1008, 32'h0, 1'b0);
      #1;
      chk("cycles loaded", bus.ReadData, 32'hFFFF_FFFE);
      tick();
      chk("cycles max", bus.ReadData, 32'hFFFF_FFFF);
      tick();
      chk("cycles wrap", bus.ReadData, 32'h0);

      // reset mid-stream with consumer ready
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b1, 32'h1000, 32'(8'hC0 + i), 1'b0);
         tick();
      end
      drive(1'b1, 1'b0, 32'h1008, 32'h0, 1'b1);
      #1;
      chk("pre-reset head", 32'(bus.TxData), 32'hC0);
      tick();
      drive(1'b0, 1'b0, 32'h1004, 32'h0, 1'b0);
      #1;
      chk("post-reset valid", 32'(bus.TxValid), 32'h0);
      chk("post-reset txdata", 32'(bus.TxData), 32'h0);
      chk("post-reset status", bus.ReadData, 32'h02);
      drive(1'b0, 1'b0, 32'h1008, 32'h0, 1'b0);
      #1;
      chk("post-reset cycles", bus.ReadData, 32'h0);

      // randomized traffic against the reference model
      for (int n = 0; n < 600; n++) begin
         sel = $urandom_range(0, 9);
         case (sel)
            0, 1, 2, 3: a = 32'($urandom_range(0, 15) * 4);
            4:          a = 32'h0000_00FC;
            5, 6:       a = 32'h0000_1000;
            7:          a = 32'h0000_1004;
            8:          a = 32'h0000_1008;
            default: begin
               case ($urandom_range(0, 3))
                  0:       a = 32'h0000_0100;
                  1:       a = 32'h0000_100C;
                  2:       a = 32'h0000_2000;
                  default: a = 32'hFFFF_F000;
               endcase
            end
         endcase
         a   = a | 32'($urandom_range(0, 3));
         d   = $urandom;
         mw  = ($urandom_range(0, 1) == 1);
         rdy = (n < 300) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
         r   = ($urandom_range(0, 63) == 0);
         drive(r, mw, a, d, rdy);
         #1;
         model_read(a, known, exp_rd);
         if (known) chk($sformatf("rand%0d ReadData @%08h", n, a), bus.ReadData, exp_rd);
         chk($sformatf("rand%0d TxValid", n), 32'(bus.TxValid), 32'(m_q.size() != 0));
         chk($sformatf("rand%0d TxData", n), 32'(bus.TxData),
             32'((m_q.size() != 0) ? m_q[0] : m_last));
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/data_mem_io.md
# data_mem_io

Data-side memory and memory-mapped I/O unit sitting directly downstream of the single-cycle datapath: it consumes the datapath's `Addr`, `WriteData` and the controller's `MemWrite`, and returns `ReadData` to the datapath's MemtoReg mux. It holds a word-addressed data RAM, a byte-wide transmit FIFO that streams decoded message characters out over a valid/ready port, a status register and a free-running cycle counter. Loads complete combinationally within the issuing cycle. Stores, FIFO pushes and pops, and counter updates take effect on the rising clock edge.

## Interface
- `RAM_WORDS`, 64: data RAM depth in 32-bit words (power of two, ≤ 1024).
- `FIFO_DEPTH`, 8: TX FIFO depth in bytes (power of two, 2..16).

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `MemWrite`  in  1  store strobe from controller.
- `Addr`  in  32  byte address (datapath ALUResult); `Addr[1:0]` ignored.
- `WriteData`  in  32  store data (datapath RD2).
- `ReadData`  out  32  load data to datapath, combinational.
- `TxData`  out  8  FIFO head byte.
- `TxValid`  out  1  FIFO non-empty.
- `TxReady`  in  1  consumer accepts `TxData` this edge.

## Operation
- Address map (word-aligned):
  - RAM: `Addr` < 4·RAM_WORDS, index `Addr[log2(RAM_WORDS)+1:2]`.
  - 0x1000 TXDATA: store pushes `WriteData[7:0]`; load returns 0.
  - 0x1004 STATUS: load returns {24'b0, count[3:0], overflow, empty, full} in bits [7:4], [2], [1], [0]; bit 3 reads 0. A store with `WriteData[2]`=1 clears overflow.
  - 0x1008 CYCLES: load returns counter; store loads `WriteData`.
  - All other addresses: load returns 0, store has no effect.
- RAM: asynchronous read, synchronous write when `MemWrite`=1. Contents are not cleared by reset.
- TX FIFO: circular buffer with read/write pointers and a count of width log2(FIFO_DEPTH)+1.
  - Push = `MemWrite` & TXDATA. Pop = `TxValid` & `TxReady`.
  - Push accepted if count < FIFO_DEPTH, or if a pop happens on the same edge.
  - Otherwise the push is dropped and overflow is set (sticky).
  - Simultaneous accepted push and pop: count unchanged, both pointers advance, mod FIFO_DEPTH.
  - Push into empty FIFO: byte becomes visible on `TxData` the next cycle. There is no same-cycle bypass.
- Cycle counter: 32-bit.
  - Increments by 1 every edge with `rst`=0 and wraps 0xFFFFFFFF→0.
  - A CYCLES store has priority over increment: the counter equals `WriteData` after the edge.
- Overflow clear and a dropped push on the same edge are impossible (different addresses), so no priority rule is needed.
- Reset (sampled high at an edge): FIFO pointers and count → 0, overflow → 0, counter → 0. All stores and pops in that cycle are ignored, including mid-stream.

## Timing
- Outputs after reset edge: `TxValid`=0, `TxData`=0, STATUS reads 0x02.
  - `ReadData` = f(Addr) combinationally at all times.
  - RAM reads return whatever contents RAM holds.
- Load latency 0 cycles (same cycle as `Addr`). A store-then-load to the same address sees new data in the following cycle.
- `TxValid` = (count≠0), registered state only, with no combinational path from `TxReady`. `TxData` = buffer[rdptr]. When empty, `TxData` holds the last-popped or reset value.
- Handshake: transfer occurs on an edge where `TxValid`&`TxReady`=1. The consumer may hold `TxReady` high permanently. `TxData` and `TxValid` do not depend on `TxReady` in the same cycle.
- Throughput: 1 byte/cycle each direction.

## Test plan
- Reset, then store 0xDEADBEEF to 0x0004 and load 0x0004 next cycle → `ReadData`=0xDEADBEEF. Load 0x0008 → unchanged prior content. Load 0x2000 → 0.
- Push 0x48, 0x49 with `TxReady`=0 → `TxValid`=1 one cycle after the first push, `TxData`=0x48, STATUS=0x20. Raise `TxReady` → 0x48 then 0x49 transferred on consecutive edges, then `TxValid`=0 and STATUS=0x02.
- With `TxReady`=0, push 9 bytes (FIFO_DEPTH=8) → 9th byte dropped, STATUS=0x85. Store 0x4 to STATUS → STATUS=0x81. Drain → the 8 original bytes come out in order.
- FIFO full with `TxReady`=1 and a push on the same edge → push accepted, count stays 8, no overflow. The pushed byte emerges 8th in sequence.
- After reset, read CYCLES at cycle 10 → 10. Store 0xFFFFFFFE → reads 0xFFFFFFFE, then 0xFFFFFFFF, then 0x00000000 on the following cycles.
- Assert `rst` for one edge with 3 bytes queued and `TxReady`=1 → no transfer on that edge. Afterwards `TxValid`=0, STATUS=0x02, CYCLES=0.
